// File: rtl/envelope_shaper_if.sv
// envelope_shaper_if: sample, note-control, config and output bundle of the
// ADSR envelope shaper. master drives samples/strobes/config, slave is the shaper.
interface envelope_shaper_if #(
    parameter int N      = 8,
    parameter int ENV_W  = 8,
    parameter int RATE_W = 12
);
    logic              sample_tick;
    logic [N-1:0]      pos_in;
    logic [N-1:0]      neg_in;
    logic              note_on;
    logic              note_off;
    logic [ENV_W-1:0]  attack_step;
    logic [ENV_W-1:0]  decay_step;
    logic [ENV_W-1:0]  release_step;
    logic [ENV_W-1:0]  sustain_level;
    logic [RATE_W-1:0] env_rate;
    logic [N-1:0]      pos_out;
    logic [N-1:0]      neg_out;
    logic              out_valid;
    logic [ENV_W-1:0]  env_level;
    logic [2:0]        env_state;
    logic              busy;

    modport master (
        output sample_tick, pos_in, neg_in, note_on, note_off,
        output attack_step, decay_step, release_step,
        output sustain_level, env_rate,
        input  pos_out, neg_out, out_valid, env_level, env_state, busy
    );

    modport slave (
        input  sample_tick, pos_in, neg_in, note_on, note_off,
        input  attack_step, decay_step, release_step,
        input  sustain_level, env_rate,
        output pos_out, neg_out, out_valid, env_level, env_state, busy
    );
endinterface

// File: rtl/envelope_shaper.sv
// envelope_shaper: ADSR envelope scaling pos/neg half-sine samples for the PWM DACs.
// Ports: clk, reset (async active-low), bus (envelope_shaper_if.slave: samples,
// note_on/off strobes, step/sustain/rate config in; scaled samples, out_valid,
// env_level, env_state, busy out).
// Option: ENVELOPE_RETRIGGER_ZERO_EN -> note_on restarts ATTACK from level 0;
// undefined -> ATTACK continues from the current level.
module envelope_shaper #(
    parameter int N      = 8,
    parameter int ENV_W  = 8,
    parameter int RATE_W = 12
) (
    input logic               clk,
    input logic               reset,
    envelope_shaper_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [ENV_W-1:0] MAX = '1;
    localparam int PW = N + ENV_W + 1;

    state_t            state_q, state_d;
    logic [ENV_W-1:0]  level_q, level_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [ENV_W-1:0]  att_q, att_d;
    logic [ENV_W-1:0]  dec_q, dec_d;
    logic [ENV_W-1:0]  rel_q, rel_d;
    logic [ENV_W-1:0]  sus_q, sus_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [N-1:0]      pos_q, pos_d;
    logic [N-1:0]      neg_q, neg_d;
    logic              vld_q, vld_d;

    logic              env_tick;
    logic [ENV_W:0]    att_sum;
    logic [ENV_W:0]    dec_diff;
    logic [ENV_W:0]    rel_diff;
    logic [ENV_W:0]    lvl_p1;
    logic [PW-1:0]     pos_prod;
    logic [PW-1:0]     neg_prod;

    // Prescaler and config latch; note_on restarts the count so a
    // coinciding tick is dropped.
    always_comb begin
        env_tick = bus.sample_tick && (cnt_q == rate_q);
        cnt_d  = cnt_q;
        att_d  = att_q;
        dec_d  = dec_q;
        rel_d  = rel_q;
        sus_d  = sus_q;
        rate_d = rate_q;
        if (bus.note_on) begin
            cnt_d  = '0;
            att_d  = bus.attack_step;
            dec_d  = bus.decay_step;
            rel_d  = bus.release_step;
            sus_d  = bus.sustain_level;
            rate_d = bus.env_rate;
        end else if (bus.sample_tick) begin
            cnt_d = env_tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Envelope FSM; the extra top bit of sum/diff flags overflow/underflow.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        att_sum  = {1'b0, level_q} + {1'b0, att_q};
        dec_diff = {1'b0, level_q} - {1'b0, dec_q};
        rel_diff = {1'b0, level_q} - {1'b0, rel_q};
        if (bus.note_on) begin
            state_d = ATTACK;
`ifdef ENVELOPE_RETRIGGER_ZERO_EN
            level_d = '0;
`endif
        end else if (bus.note_off &&
                     (state_q == ATTACK || state_q == DECAY ||
                      state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else if (env_tick) begin
            unique case (state_q)
                ATTACK: begin
                    if (att_q == '0 || att_sum >= {1'b0, MAX}) begin
                        level_d = MAX;
                        state_d = DECAY;
                    end else begin
                        level_d = att_sum[ENV_W-1:0];
                    end
                end
                DECAY: begin
                    if (sus_q == MAX || dec_q == '0 || dec_diff[ENV_W] ||
                        dec_diff[ENV_W-1:0] <= sus_q) begin
                        level_d = sus_q;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = dec_diff[ENV_W-1:0];
                    end
                end
                RELEASE: begin
                    if (rel_q == '0 || rel_diff[ENV_W] ||
                        rel_diff[ENV_W-1:0] == '0) begin
                        level_d = '0;
                        state_d = IDLE;
                    end else begin
                        level_d = rel_diff[ENV_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Scale by (level+1)/2^ENV_W so full scale passes x unchanged;
    // level 0 is forced silent.
    always_comb begin
        lvl_p1   = {1'b0, level_q} + 1'b1;
        pos_prod = {{(ENV_W+1){1'b0}}, bus.pos_in} * {{N{1'b0}}, lvl_p1};
        neg_prod = {{(ENV_W+1){1'b0}}, bus.neg_in} * {{N{1'b0}}, lvl_p1};
        pos_d    = pos_q;
        neg_d    = neg_q;
        vld_d    = bus.sample_tick;
        if (bus.sample_tick) begin
            pos_d = (level_q == '0) ? '0 : pos_prod[ENV_W +: N];
            neg_d = (level_q == '0) ? '0 : neg_prod[ENV_W +: N];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
            dec_q   <= '0;
            rel_q   <= '0;
            sus_q   <= '0;
            rate_q  <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            dec_q   <= dec_d;
            rel_q   <= rel_d;
            sus_q   <= sus_d;
            rate_q  <= rate_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.pos_out   = pos_q;
    assign bus.neg_out   = neg_q;
    assign bus.out_valid = vld_q;
    assign bus.env_level = level_q;
    assign bus.env_state = state_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: directed table + hand sequences for envelope_shaper.
// Covers ADSR levels, scaling, prescaler, retrigger, edge cases, async reset.
module tb_envelope_shaper;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   prev_lvl;
    int   base;

    envelope_shaper_if #(.N(8), .ENV_W(8), .RATE_W(12)) bus ();

    envelope_shaper #(.N(8), .ENV_W(8), .RATE_W(12)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic       on;
        logic       off;
        logic [7:0] pin;
        logic [7:0] nin;
        logic [7:0] lvl;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(logic tk, logic on, logic off,
                                logic [7:0] pin, logic [7:0] nin,
                                logic [7:0] lvl, logic [2:0] st);
        vec_t v;
        v.tk = tk; v.on = on; v.off = off;
        v.pin = pin; v.nin = nin; v.lvl = lvl; v.st = st;
        return v;
    endfunction

    function automatic int scale(int x, int l);
        if (l == 0) return 0;
        return (x * (l + 1)) / 256;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] s, input logic [7:0] r,
                       input logic [11:0] rate);
        bus.attack_step   = a;
        bus.decay_step    = d;
        bus.sustain_level = s;
        bus.release_step  = r;
        bus.env_rate      = rate;
    endtask

    task automatic step(input logic tk, input logic on, input logic off,
                        input logic [7:0] pin, input logic [7:0] nin);
        @(negedge clk);
        bus.sample_tick = tk;
        bus.note_on     = on;
        bus.note_off    = off;
        bus.pos_in      = pin;
        bus.neg_in      = nin;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        bus.note_on     = 1'b0;
        bus.note_off    = 1'b0;
    endtask

    task automatic tick(input logic [7:0] pin);
        step(1'b1, 1'b0, 1'b0, pin, 8'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_env(input string nm, input int lvl, input int st);
        chk({nm, "_lvl"}, 32'(bus.env_level), 32'(lvl));
        chk({nm, "_st"}, 32'(bus.env_state), 32'(st));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.sample_tick = 1'b0;
        bus.note_on     = 1'b0;
        bus.note_off    = 1'b0;
        bus.pos_in      = '0;
        bus.neg_in      = '0;
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 12'd0);

`ifdef ENVELOPE_RETRIGGER_ZERO_EN
        base = 0;
`else
        base = 10;
`endif

        vecs[0]  = mk(0, 1, 0,   0,   0,   0, 1);
        vecs[1]  = mk(1, 0, 0, 200, 100,  64, 1);
        vecs[2]  = mk(1, 0, 0, 200, 100, 128, 1);
        vecs[3]  = mk(1, 0, 0, 250,  17, 192, 1);
        vecs[4]  = mk(1, 0, 0,  99, 255, 255, 2);
        vecs[5]  = mk(1, 0, 0, 200, 123, 239, 2);
        vecs[6]  = mk(1, 0, 0, 255,   1, 223, 2);
        vecs[7]  = mk(1, 0, 0,  77,  88, 207, 2);
        vecs[8]  = mk(1, 0, 0,  10, 200, 191, 2);
        vecs[9]  = mk(1, 0, 0, 128, 128, 175, 2);
        vecs[10] = mk(1, 0, 0,  50,  60, 159, 2);
        vecs[11] = mk(1, 0, 0, 200, 200, 143, 2);
        vecs[12] = mk(1, 0, 0, 180,  40, 128, 3);
        vecs[13] = mk(1, 0, 0, 200, 100, 128, 3);
        vecs[14] = mk(0, 0, 1,   0,   0, 128, 4);
        vecs[15] = mk(1, 0, 0, 200, 100,  96, 4);
        vecs[16] = mk(1, 0, 0, 200, 100,  64, 4);
        vecs[17] = mk(1, 0, 0, 200, 100,  32, 4);
        vecs[18] = mk(1, 0, 0, 200, 100,   0, 0);
        vecs[19] = mk(1, 0, 0, 200, 100,   0, 0);
        vecs[20] = mk(0, 0, 1,   0,   0,   0, 0);

        #1;
        chk("rst_pos", 32'(bus.pos_out), 32'd0);
        chk("rst_neg", 32'(bus.neg_out), 32'd0);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_lvl", 32'(bus.env_level), 32'd0);
        chk("rst_st", 32'(bus.env_state), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        do_reset();

        // Basic ADSR with scaled outputs, 4 clk per sample_tick
        prev_lvl = 0;
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].tk, vecs[i].on, vecs[i].off,
                 vecs[i].pin, vecs[i].nin);
            chk($sformatf("v%0d_lvl", i), 32'(bus.env_level),
                32'(vecs[i].lvl));
            chk($sformatf("v%0d_st", i), 32'(bus.env_state),
                32'(vecs[i].st));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy),
                32'(vecs[i].st != 3'd0));
            chk($sformatf("v%0d_vld", i), 32'(bus.out_valid),
                32'(vecs[i].tk));
            if (vecs[i].tk) begin
                chk($sformatf("v%0d_pos", i), 32'(bus.pos_out),
                    32'(scale(int'(vecs[i].pin), prev_lvl)));
                chk($sformatf("v%0d_neg", i), 32'(bus.neg_out),
                    32'(scale(int'(vecs[i].nin), prev_lvl)));
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_vld_lo", i), 32'(bus.out_valid), 32'd0);
                repeat (2) @(posedge clk);
                #1;
            end
            prev_lvl = int'(vecs[i].lvl);
        end
        // Full scale 255 -> exact passthrough
        chk("full_scale", 32'(scale(200, 255)), 32'd200);

        // Level 127 scales 200 to 100
        do_reset();
        cfg(8'd127, 8'd16, 8'd128, 8'd32, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(8'd0);
        chk_env("s127a", 127, 1);
        tick(8'd200);
        chk("s127_pos", 32'(bus.pos_out), 32'd100);
        chk_env("s127b", 254, 1);

        // Prescaler: rate 3, then note_on mid-count restarts the count
        do_reset();
        cfg(8'd10, 8'd16, 8'd128, 8'd32, 12'd3);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(8'd0);
            chk($sformatf("pre_a%0d", k), 32'(bus.env_level), 32'd0);
        end
        tick(8'd0);
        chk("pre_a4", 32'(bus.env_level), 32'd10);
        tick(8'd0);
        tick(8'd0);
        chk("pre_mid", 32'(bus.env_level), 32'd10);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(8'd0);
            chk($sformatf("pre_b%0d", k), 32'(bus.env_level),
                32'(base));
        end
        tick(8'd0);
        chk("pre_b4", 32'(bus.env_level), 32'(base + 10));

        // Retrigger during RELEASE at 96
        do_reset();
        cfg(8'd64, 8'd16, 8'd128, 8'd32, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        repeat (13) tick(8'd0);
        chk_env("rt_sus", 128, 3);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        tick(8'd0);
        chk_env("rt_rel", 96, 4);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        chk_env("rt_on", base == 0 ? 0 : 96, 1);
        tick(8'd0);
        chk_env("rt_tick", base == 0 ? 64 : 160, 1);

        // note_on and note_off together -> ATTACK
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        chk("both_pre", 32'(bus.env_state), 32'd4);
        step(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
        chk("both_st", 32'(bus.env_state), 32'd1);

        // note_off in IDLE is ignored
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        chk("off_idle", 32'(bus.env_state), 32'd0);

        // sustain 255: DECAY lasts one tick
        cfg(8'd255, 8'd16, 8'd255, 8'd32, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(8'd0);
        chk_env("s255_a", 255, 2);
        tick(8'd0);
        chk_env("s255_d", 255, 3);

        // All steps zero: one tick per phase
        cfg(8'd0, 8'd0, 8'd100, 8'd0, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(8'd0);
        chk_env("z_a", 255, 2);
        tick(8'd0);
        chk_env("z_d", 100, 3);
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        tick(8'd0);
        chk_env("z_r", 0, 0);

        // Async reset mid-SUSTAIN with nonzero outputs
        do_reset();
        cfg(8'd0, 8'd0, 8'd128, 8'd32, 12'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        tick(8'd0);
        tick(8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd200, 8'd120);
        chk("ar_pos_pre", 32'(bus.pos_out), 32'd100);
        chk("ar_neg_pre", 32'(bus.neg_out), 32'd60);
        chk("ar_st_pre", 32'(bus.env_state), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pos", 32'(bus.pos_out), 32'd0);
        chk("ar_neg", 32'(bus.neg_out), 32'd0);
        chk("ar_lvl", 32'(bus.env_level), 32'd0);
        chk("ar_st", 32'(bus.env_state), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_idle", 32'(bus.env_state), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'd200, 8'd200);
        chk("ar_vld", 32'(bus.out_valid), 32'd1);
        chk("ar_pos0", 32'(bus.pos_out), 32'd0);
        chk("ar_neg0", 32'(bus.neg_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
